user_burst_memory_target: RTL and testbench



---
 rtl/user_burst_memory_target.sv | 158 +++++++++++++++
 tb/tb_user_burst_memory_target.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/user_burst_memory_target.sv
// Burst memory target for the simplified user bus: independent write and read engines on a
// single-clock RAM. Optional define USER_BURST_MEMORY_WLAST_CHECK_EN adds a sticky wlast_err flag.
module user_burst_memory_target #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 10
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  awvalid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic                  arvalid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
`ifdef USER_BURST_MEMORY_WLAST_CHECK_EN
  ,
  output logic                  wlast_err
`endif
);

  localparam int unsigned ByteOffs = $clog2(DATA_WIDTH / 8);
  localparam int unsigned Depth    = 2 ** MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RFetch, RData} r_state_e;

  logic [DATA_WIDTH-1:0] mem [Depth];

  w_state_e                w_state;
  logic [MEM_ADDR_WIDTH-1:0] w_idx;
  logic [7:0]                w_cnt;
  r_state_e                r_state;
  logic [MEM_ADDR_WIDTH-1:0] r_idx;
  logic [7:0]                r_cnt;

  logic w_beat;
  assign w_beat = wvalid && wready;

  // Only the index bits are meaningful; the rest of the address and wlast may be ignored.
  logic unused_bits;
  assign unused_bits = ^{wlast, awaddr, araddr};

  always_ff @(posedge ACLK) begin
    if (w_beat) mem[w_idx] <= wdata;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= WIdle;
      w_idx   <= '0;
      w_cnt   <= '0;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      unique case (w_state)
        WIdle: begin
          if (awvalid && awready) begin
            w_idx   <= awaddr[ByteOffs +: MEM_ADDR_WIDTH];
            w_cnt   <= awlen;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= WData;
          end
        end
        WData: begin
          if (w_beat) begin
            if (w_cnt == 8'd0) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              w_state <= WResp;
            end else begin
              w_idx <= w_idx + MEM_ADDR_WIDTH'(1);
              w_cnt <= w_cnt - 8'd1;
            end
          end
        end
        WResp: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= WIdle;
          end
        end
        default: w_state <= WIdle;
      endcase
    end
  end

`ifdef USER_BURST_MEMORY_WLAST_CHECK_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wlast_err <= 1'b0;
    end else if (w_beat && (wlast != (w_cnt == 8'd0))) begin
      wlast_err <= 1'b1;
    end
  end
`endif

  // The fetch reads mem with the old value when a write hits the same word (read-first).
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= RIdle;
      r_idx   <= '0;
      r_cnt   <= '0;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
    end else begin
      unique case (r_state)
        RIdle: begin
          if (arvalid && arready) begin
            r_idx   <= araddr[ByteOffs +: MEM_ADDR_WIDTH];
            r_cnt   <= arlen;
            arready <= 1'b0;
            r_state <= RFetch;
          end
        end
        RFetch: begin
          rdata   <= mem[r_idx];
          rvalid  <= 1'b1;
          rlast   <= (r_cnt == 8'd0);
          r_state <= RData;
        end
        RData: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (r_cnt == 8'd0) begin
              arready <= 1'b1;
              r_state <= RIdle;
            end else begin
              r_idx   <= r_idx + MEM_ADDR_WIDTH'(1);
              r_cnt   <= r_cnt - 8'd1;
              r_state <= RFetch;
            end
          end
        end
        default: r_state <= RIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_user_burst_memory_target.sv
// Directed bench for user_burst_memory_target: bursts, wrap, backpressure, read-first, reset.
module tb_user_burst_memory_target;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned MEM_ADDR_WIDTH = 10;

  logic                  ACLK = 1'b0;
  logic                  ARESETN = 1'b0;
  logic                  awvalid = 1'b0;
  logic [ADDR_WIDTH-1:0] awaddr = '0;
  logic [7:0]            awlen = '0;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata = '0;
  logic                  wlast = 1'b0;
  logic                  wvalid = 1'b0;
  logic                  wready;
  logic                  bvalid;
  logic                  bready = 1'b0;
  logic                  arvalid = 1'b0;
  logic [ADDR_WIDTH-1:0] araddr = '0;
  logic [7:0]            arlen = '0;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready = 1'b0;
`ifdef USER_BURST_MEMORY_WLAST_CHECK_EN
  logic                  wlast_err;
`endif

  int n_checks = 0;
  int n_bad    = 0;

  always #5 ACLK = ~ACLK;

  user_burst_memory_target #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .awvalid (awvalid),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awready (awready),
    .wdata   (wdata),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bvalid  (bvalid),
    .bready  (bready),
    .arvalid (arvalid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arready (arready),
    .rdata   (rdata),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
`ifdef USER_BURST_MEMORY_WLAST_CHECK_EN
    ,
    .wlast_err (wlast_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Write len+1 beats of base+i; wlast raised on beat wlast_at; bready held low hold cycles.
  task automatic write_burst(input logic [31:0] addr, input int len, input logic [31:0] base,
                             input int wlast_at, input int hold);
    @(negedge ACLK);
    check("aw_ready_idle", awready, 1);
    awvalid = 1'b1;
    awaddr  = addr;
    awlen   = 8'(len);
    @(negedge ACLK);
    awvalid = 1'b0;
    check("aw_ready_busy", awready, 0);
    check("b_valid_early", bvalid, 0);
    for (int i = 0; i <= len; i++) begin
      check("w_ready", wready, 1);
      wvalid = 1'b1;
      wdata  = base + 32'(i);
      wlast  = (i == wlast_at);
      @(negedge ACLK);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    check("b_valid", bvalid, 1);
    check("w_ready_resp", wready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check("b_valid_held", bvalid, 1);
      check("aw_ready_held", awready, 0);
    end
    bready = 1'b1;
    @(negedge ACLK);
    bready = 1'b0;
    check("b_valid_clear", bvalid, 0);
    check("aw_ready_back", awready, 1);
  endtask

  // Read len+1 beats expecting base+i; optionally stall one cycle per beat.
  task automatic read_burst(input logic [31:0] addr, input int len, input logic [31:0] base,
                            input bit stall);
    logic [31:0] held;
    @(negedge ACLK);
    check("ar_ready_idle", arready, 1);
    arvalid = 1'b1;
    araddr  = addr;
    arlen   = 8'(len);
    @(negedge ACLK);
    arvalid = 1'b0;
    check("r_valid_fetch", rvalid, 0);
    check("ar_ready_busy", arready, 0);
    for (int i = 0; i <= len; i++) begin
      @(negedge ACLK);
      check("r_valid", rvalid, 1);
      check("r_data", rdata, base + 32'(i));
      check("r_last", rlast, (i == len));
      held = rdata;
      if (stall) begin
        rready = 1'b0;
        @(negedge ACLK);
        check("r_valid_stall", rvalid, 1);
        check("r_data_stall", rdata, base + 32'(i));
        check("r_last_stall", rlast, (i == len));
      end
      rready = 1'b1;
      @(negedge ACLK);
      rready = 1'b0;
      check("r_valid_bubble", rvalid, 0);
    end
    check("ar_ready_done", arready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_arready", arready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;

    // Single beat write/read.
    write_burst(32'h10, 0, 32'hDEADBEEF, 0, 0);
    read_burst(32'h10, 0, 32'hDEADBEEF, 1'b0);

    // 16-beat burst, rready toggling.
    write_burst(32'h100, 15, 32'h0, 15, 0);
    read_burst(32'h100, 15, 32'h0, 1'b1);

    // Wrap: words 1022,1023,0,1.
    write_burst(32'hFF8, 3, 32'h100, 3, 0);
    read_burst(32'hFF8, 3, 32'h100, 1'b0);
    read_burst(32'h0, 1, 32'h102, 1'b0);

    // B backpressure for 5 cycles, then AW accepted right after.
    write_burst(32'h14, 0, 32'h55, 0, 5);

    // Same-cycle write and fetch of word 5 returns the old value.
    @(negedge ACLK);
    awvalid = 1'b1; awaddr = 32'h14; awlen = 8'd0;
    arvalid = 1'b1; araddr = 32'h14; arlen = 8'd0;
    @(negedge ACLK);
    awvalid = 1'b0; arvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h77; wlast = 1'b1;
    @(negedge ACLK);
    wvalid = 1'b0; wlast = 1'b0;
    check("rf_bvalid", bvalid, 1);
    check("rf_rvalid", rvalid, 1);
    check("rf_rdata_old", rdata, 32'h55);
    bready = 1'b1; rready = 1'b1;
    @(negedge ACLK);
    bready = 1'b0; rready = 1'b0;
    check("rf_bvalid_clr", bvalid, 0);
    check("rf_rvalid_clr", rvalid, 0);
    read_burst(32'h14, 0, 32'h77, 1'b0);

    // Reset in the middle of an 8-beat read.
    @(negedge ACLK);
    arvalid = 1'b1; araddr = 32'h100; arlen = 8'd7;
    @(negedge ACLK);
    arvalid = 1'b0;
    @(negedge ACLK);
    check("mid_rvalid", rvalid, 1);
    check("mid_rdata", rdata, 32'h0);
    #2;
    ARESETN = 1'b0;
    #1;
    check("arst_rvalid", rvalid, 0);
    check("arst_arready", arready, 1);
    check("arst_rlast", rlast, 0);
    check("arst_rdata", rdata, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    read_burst(32'h100, 3, 32'h0, 1'b0);
    read_burst(32'h10, 0, 32'hDEADBEEF, 1'b0);

`ifdef USER_BURST_MEMORY_WLAST_CHECK_EN
    check("wlerr_clean", wlast_err, 0);
    write_burst(32'h200, 3, 32'h300, 1, 0);
    check("wlerr_set", wlast_err, 1);
    read_burst(32'h200, 3, 32'h300, 1'b0);
    check("wlerr_sticky", wlast_err, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
